fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fd_pipe_reg.sv | 39 +++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage: RV32 opcode field values, bubble encoding, FSM states.
package fetch_stage_pkg;

    // Opcode constants are D_inst[6:2]; the low two bits are always 2'b11 for RV32I.
    localparam logic [4:0] OP_R_TYPE = 5'b01100;
    localparam logic [4:0] OP_I_TYPE = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_S_TYPE = 5'b01000;
    localparam logic [4:0] OP_B_TYPE = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

    typedef enum logic {
        StFetch,
        StHeld
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_stage_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic [31:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ready,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ready,
        output im_rdata
    );
endinterface

// File: rtl/fd_pipe_reg.sv
// Fetch/decode pipeline register: load a new word, insert a bubble (PC kept), or hold.
module fd_pipe_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= 32'h0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_inst  <= i_inst;
            r_valid <= 1'b1;
        end else if (i_bubble) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end
    end

    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// In-order fetch stage with a one-entry skid buffer so a word accepted under stall is not lost.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        im,
    input  logic                 next_pc_sel,
    input  logic [31:0]          jb_target,
    input  logic                 stall,
    output logic [31:0]          D_pc,
    output logic [31:0]          D_inst,
    output logic                 D_valid,
    output logic [4:0]           opcode,
    output logic [2:0]           func3,
    output logic                 func7,
    output logic [4:0]           rd,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic                 fetch_busy
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_skid_pc;
    logic [31:0]  r_skid_inst;

    logic        w_accept;
    logic        w_load;
    logic        w_bubble;
    logic [31:0] w_load_pc;
    logic [31:0] w_load_inst;
    logic [31:0] w_redirect_pc;

    assign im.im_req      = (r_state == StFetch) && rst;
    assign im.im_addr     = r_pc;
    assign w_accept       = im.im_req && im.im_ready;
    assign w_redirect_pc  = jb_target & 32'hFFFF_FFFC;

    always_comb begin
        w_load      = 1'b0;
        w_bubble    = 1'b0;
        w_load_pc   = r_skid_pc;
        w_load_inst = r_skid_inst;
        if (next_pc_sel) begin
            w_bubble = 1'b1;
        end else if (r_state == StFetch) begin
            if (w_accept && !stall) begin
                w_load      = 1'b1;
                w_load_pc   = r_pc;
                w_load_inst = im.im_rdata;
            end else if (!w_accept && !stall) begin
                w_bubble = 1'b1;
            end
        end else if (!stall) begin
            w_load = 1'b1;
        end
    end

    // Redirect wins over everything; an im_ready in the same cycle is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StFetch;
            r_pc        <= RESET_PC;
            r_skid_pc   <= 32'h0;
            r_skid_inst <= 32'h0;
        end else if (next_pc_sel) begin
            r_state     <= StFetch;
            r_pc        <= w_redirect_pc;
            r_skid_pc   <= 32'h0;
            r_skid_inst <= 32'h0;
        end else begin
            unique case (r_state)
                StFetch: begin
                    if (w_accept) begin
                        r_pc <= r_pc + 32'd4;
                        if (stall) begin
                            r_skid_pc   <= r_pc;
                            r_skid_inst <= im.im_rdata;
                            r_state     <= StHeld;
                        end
                    end
                end
                StHeld: begin
                    if (!stall) begin
                        r_state <= StFetch;
                    end
                end
                default: r_state <= StFetch;
            endcase
        end
    end

    fd_pipe_reg #(
        .NOP_INST (NOP_INST)
    ) u_fd_pipe_reg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_pc     (w_load_pc),
        .i_inst   (w_load_inst),
        .o_pc     (D_pc),
        .o_inst   (D_inst),
        .o_valid  (D_valid)
    );

    assign opcode     = D_inst[6:2];
    assign func3      = D_inst[14:12];
    assign func7      = D_inst[30];
    assign rd         = D_inst[11:7];
    assign rs1        = D_inst[19:15];
    assign rs2        = D_inst[24:20];
    assign fetch_busy = (r_state == StHeld);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded directed bench for fetch_stage: stimulus pushes expected post-edge state, monitor checks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        next_pc_sel;
    logic [31:0] jb_target;
    logic        stall;
    logic        tb_ready;
    logic [31:0] D_pc;
    logic [31:0] D_inst;
    logic        D_valid;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic        func7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fetch_busy;

    always #5 clk = ~clk;

    fetch_stage_if im_bus ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h40B5_04B3;   // sub x9, x10, x11
        return 32'h1000_0000 + a;
    endfunction

    assign im_bus.im_ready = tb_ready;
    assign im_bus.im_rdata = tb_ready ? mem_word(im_bus.im_addr) : 32'hDEAD_BEEF;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .im          (im_bus.master),
        .next_pc_sel (next_pc_sel),
        .jb_target   (jb_target),
        .stall       (stall),
        .D_pc        (D_pc),
        .D_inst      (D_inst),
        .D_valid     (D_valid),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .fetch_busy  (fetch_busy)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic [31:0] addr;
        logic        busy;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic st, input logic nps, input logic [31:0] jb,
                       input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_valid,
                       input logic [31:0] e_addr, input logic e_busy);
        exp_t e;
        @(negedge clk);
        tb_ready    = rdy;
        stall       = st;
        next_pc_sel = nps;
        jb_target   = jb;
        e = '{pc: e_pc, inst: e_inst, valid: e_valid, addr: e_addr, busy: e_busy};
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_im_req"},  {31'h0, im_bus.im_req}, 32'h0);
        check({tag, "_im_addr"}, im_bus.im_addr, 32'h0);
        check({tag, "_D_pc"},    D_pc, 32'h0);
        check({tag, "_D_inst"},  D_inst, 32'h0000_0013);
        check({tag, "_D_valid"}, {31'h0, D_valid}, 32'h0);
        check({tag, "_busy"},    {31'h0, fetch_busy}, 32'h0);
        check({tag, "_opcode"},  {27'h0, opcode}, 32'h4);
        check({tag, "_rd"},      {27'h0, rd}, 32'h0);
    endtask

    // Monitor: one expected entry per clock edge while enabled.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: got edge with D_pc %h, expected no edge", D_pc);
                end else begin
                    e = sb_q.pop_front();
                    check("D_pc",       D_pc, e.pc);
                    check("D_inst",     D_inst, e.inst);
                    check("D_valid",    {31'h0, D_valid}, {31'h0, e.valid});
                    check("im_addr",    im_bus.im_addr, e.addr);
                    check("fetch_busy", {31'h0, fetch_busy}, {31'h0, e.busy});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tb_ready    = 1'b0;
        stall       = 1'b0;
        next_pc_sel = 1'b0;
        jb_target   = 32'h0;
        rst         = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");

        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rel_im_req",  {31'h0, im_bus.im_req}, 32'h1);
        check("rel_im_addr", im_bus.im_addr, 32'h0);
        mon_en = 1'b1;

        //  rdy  st  nps jb             D_pc          D_inst        V     im_addr       busy
        cyc(1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        32'h1000_0000, 1'b1, 32'h4,        1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0,    32'h4,        32'h1000_0004, 1'b1, 32'h8,        1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0,    32'h4,        32'h0000_0013, 1'b0, 32'h8,        1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0,    32'h4,        32'h0000_0013, 1'b0, 32'h8,        1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0,    32'h8,        32'h1000_0008, 1'b1, 32'hC,        1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0,    32'h8,        32'h1000_0008, 1'b1, 32'h10,       1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0,    32'hC,        32'h1000_000C, 1'b1, 32'h10,       1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0,    32'h10,       32'h1000_0010, 1'b1, 32'h14,       1'b0);
        // Word at 0x14 goes into the skid, then a redirect discards it.
        cyc(1'b1, 1'b1, 1'b0, 32'h0,    32'h10,       32'h1000_0010, 1'b1, 32'h18,       1'b1);
        cyc(1'b1, 1'b1, 1'b1, 32'h103,  32'h10,       32'h0000_0013, 1'b0, 32'h100,      1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0,    32'h100,      32'h40B5_04B3, 1'b1, 32'h104,      1'b0);
        #2;
        check("f_opcode", {27'h0, opcode}, 32'h0C);
        check("f_rd",     {27'h0, rd},     32'h09);
        check("f_rs1",    {27'h0, rs1},    32'h0A);
        check("f_rs2",    {27'h0, rs2},    32'h0B);
        check("f_func3",  {29'h0, func3},  32'h0);
        check("f_func7",  {31'h0, func7},  32'h1);
        // Redirect while a word is being accepted: that word is dropped.
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h100, 32'h0000_0013, 1'b0, 32'hFFFF_FFFC, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0,    32'hFFFF_FFFC, 32'h0FFF_FFFC, 1'b1, 32'h0,       1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        32'h1000_0000, 1'b1, 32'h4,        1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0,    32'h0,        32'h1000_0000, 1'b1, 32'h4,        1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0,    32'h4,        32'h1000_0004, 1'b1, 32'h8,        1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0,    32'h4,        32'h1000_0004, 1'b1, 32'hC,        1'b1);

        // Asynchronous reset while HELD.
        @(negedge clk);
        mon_en = 1'b0;
        stall  = 1'b0;
        rst    = 1'b0;
        #1;
        check_reset_outputs("mid");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rel2_im_req",  {31'h0, im_bus.im_req}, 32'h1);
        check("rel2_im_addr", im_bus.im_addr, 32'h0);
        mon_en = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        32'h1000_0000, 1'b1, 32'h4,        1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        32'h0000_0013, 1'b0, 32'h4,        1'b0);

        @(negedge clk);
        mon_en = 1'b0;
        check("sb_drained", sb_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
